// File: rtl/clic_arb_pkg.sv
// Shared types and helpers for the CLIC sequential interrupt arbiter.
// The candidate struct is sized for up to 256 sources and 8-bit levels.
package clic_arb_pkg;

   localparam int unsigned ArbMaxSrc    = 256;
   localparam int unsigned ArbMaxLevelW = 8;

   function automatic int unsigned clic_arb_idw(input int unsigned num_src);
      return (num_src > 1) ? $clog2(num_src) : 1;
   endfunction

   localparam int unsigned CandIdW    = clic_arb_idw(ArbMaxSrc);
   localparam int unsigned CandLevelW = ArbMaxLevelW;

   typedef logic [1:0] clic_arb_state_e;
   localparam clic_arb_state_e StIdle = 2'd0;
   localparam clic_arb_state_e StScan = 2'd1;
   localparam clic_arb_state_e StHold = 2'd2;

   typedef struct packed {
      logic                  valid;
      logic [CandIdW-1:0]    id;
      logic [CandLevelW-1:0] level;
   } clic_arb_cand_t;

endpackage

// File: rtl/clic_arb_chunk_max.sv
// Combinational max-level reduction over one chunk of sources.
// Eligible means pending, enabled and level strictly above the threshold.
module clic_arb_chunk_max
   import clic_arb_pkg::*;
#(
   parameter int unsigned SrcPerCycle = 16,
   parameter int unsigned LevelW      = 8,
   parameter int unsigned IdW         = 8
) (
   input  logic [SrcPerCycle-1:0]        ip_i,
   input  logic [SrcPerCycle-1:0]        ie_i,
   input  logic [SrcPerCycle*LevelW-1:0] level_i,
   input  logic [LevelW-1:0]             mth_i,
   input  logic [IdW-1:0]                base_id_i,
   output clic_arb_cand_t                cand_o
);

   clic_arb_cand_t best;
   logic [LevelW-1:0] lvl;

   always_comb begin
      best = '0;
      lvl  = '0;
      // Strict compare while walking upward keeps the lowest index on ties.
      for (int unsigned i = 0; i < SrcPerCycle; i++) begin
         lvl = level_i[i*LevelW +: LevelW];
         if (ip_i[i] && ie_i[i] && (lvl > mth_i) &&
             (!best.valid || (lvl > best.level[LevelW-1:0]))) begin
            best.valid = 1'b1;
            best.id    = CandIdW'(base_id_i) + CandIdW'(i);
            best.level = CandLevelW'(lvl);
         end
      end
      cand_o = best;
   end

endmodule

// File: rtl/clic_arb_irq_arbiter.sv
// Auxiliary pass-through cell; the arbiter top lives in rtl/clic_irq_arbiter.sv.
module clic_arb_irq_arbiter_unused_stub (
   input  logic a_i,
   output logic a_o
);
   assign a_o = a_i;
endmodule

// File: rtl/clic_irq_arbiter.sv
// Multi-cycle CLIC priority arbiter: scans SrcPerCycle sources per cycle and offers the winner.
// CLIC_ARB_PREEMPT_EN enables a background rescan in HOLD that can upgrade the offer.
module clic_irq_arbiter
   import clic_arb_pkg::*;
#(
   parameter  int unsigned NumSrc      = 256,
   parameter  int unsigned SrcPerCycle = 16,
   parameter  int unsigned LevelW      = 8,
   localparam int unsigned IdW         = clic_arb_idw(NumSrc)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumSrc-1:0]        ip_i,
   input  logic [NumSrc-1:0]        ie_i,
   input  logic [NumSrc*LevelW-1:0] level_i,
   input  logic [LevelW-1:0]        mth_i,
   output logic                     irq_valid_o,
   output logic [IdW-1:0]           irq_id_o,
   output logic [LevelW-1:0]        irq_level_o,
   input  logic                     irq_ready_i,
   output logic                     scan_busy_o
);

   localparam int unsigned NumChunks = NumSrc / SrcPerCycle;
   localparam int unsigned ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;

   clic_arb_state_e   state_q, state_d;
   logic [ChunkW-1:0] chunk_q, chunk_d;
   clic_arb_cand_t    best_q, best_d;
   logic              valid_q, valid_d;
   logic [IdW-1:0]    id_q, id_d;
   logic [LevelW-1:0] level_q, level_d;

   logic [IdW-1:0] base_id;
   clic_arb_cand_t chunk_cand;
   clic_arb_cand_t merged;
   logic           last_chunk;
   logic           held_ok;

   assign base_id    = IdW'(chunk_q * SrcPerCycle);
   assign last_chunk = (chunk_q == ChunkW'(NumChunks - 1));

   clic_arb_chunk_max #(
      .SrcPerCycle(SrcPerCycle),
      .LevelW     (LevelW),
      .IdW        (IdW)
   ) u_chunk_max (
      .ip_i     (ip_i[base_id +: SrcPerCycle]),
      .ie_i     (ie_i[base_id +: SrcPerCycle]),
      .level_i  (level_i[int'(base_id) * LevelW +: SrcPerCycle*LevelW]),
      .mth_i    (mth_i),
      .base_id_i(base_id),
      .cand_o   (chunk_cand)
   );

   // Cross-chunk merge is strict so an earlier (lower-ID) best survives ties.
   always_comb begin
      merged = best_q;
      if (chunk_cand.valid && (!best_q.valid || (chunk_cand.level > best_q.level))) begin
         merged = chunk_cand;
      end
   end

   assign held_ok = ip_i[id_q] && ie_i[id_q] &&
                    (level_i[int'(id_q) * LevelW +: LevelW] > mth_i);

   always_comb begin
      state_d = state_q;
      chunk_d = chunk_q;
      best_d  = best_q;
      valid_d = valid_q;
      id_d    = id_q;
      level_d = level_q;
      case (state_q)
         StIdle: begin
            state_d = StScan;
            chunk_d = '0;
            best_d  = '0;
         end
         StScan: begin
            best_d  = merged;
            chunk_d = chunk_q + 1'b1;
            if (last_chunk) begin
               chunk_d = '0;
               best_d  = '0;
               if (merged.valid) begin
                  state_d = StHold;
                  valid_d = 1'b1;
                  id_d    = merged.id[IdW-1:0];
                  level_d = merged.level[LevelW-1:0];
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StHold: begin
`ifdef CLIC_ARB_PREEMPT_EN
            best_d  = merged;
            chunk_d = chunk_q + 1'b1;
            if (last_chunk) begin
               chunk_d = '0;
               best_d  = '0;
               if (merged.valid && (merged.level[LevelW-1:0] > level_q)) begin
                  id_d    = merged.id[IdW-1:0];
                  level_d = merged.level[LevelW-1:0];
               end
            end
`endif
            // A claim and a withdraw both leave HOLD; the claim has already been sampled.
            if (irq_ready_i || !held_ok) begin
               state_d = StIdle;
               valid_d = 1'b0;
               id_d    = '0;
               level_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         chunk_q <= '0;
         best_q  <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         best_q  <= best_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         level_q <= level_d;
      end
   end

   assign irq_valid_o = valid_q;
   assign irq_id_o    = id_q;
   assign irq_level_o = level_q;
   assign scan_busy_o = (state_q == StScan);

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed self-checking bench for clic_irq_arbiter at default parameters.
// Define CLIC_ARB_PREEMPT_EN for both RTL and bench to check the preemptive build.
module tb_clic_irq_arbiter;

   logic          clk;
   logic          rst;
   logic [255:0]  ip;
   logic [255:0]  ie;
   logic [2047:0] level;
   logic [7:0]    mth;
   logic          irq_valid;
   logic [7:0]    irq_id;
   logic [7:0]    irq_level;
   logic          irq_ready;
   logic          scan_busy;

   int total = 0;
   int bad   = 0;

   clic_irq_arbiter dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .ip_i       (ip),
      .ie_i       (ie),
      .level_i    (level),
      .mth_i      (mth),
      .irq_valid_o(irq_valid),
      .irq_id_o   (irq_id),
      .irq_level_o(irq_level),
      .irq_ready_i(irq_ready),
      .scan_busy_o(scan_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_src();
      ip        = '0;
      ie        = '0;
      level     = '0;
      mth       = '0;
      irq_ready = 1'b0;
   endtask

   task automatic set_src(input int id, input int lvl);
      ip[id]            = 1'b1;
      ie[id]            = 1'b1;
      level[id*8 +: 8]  = 8'(lvl);
   endtask

   // Returns with the first reset-free cycle (IDLE) current.
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output int n);
      n = 0;
      while (!irq_valid && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      clear_src();
      rst = 1'b1;
      tick();
      tick();
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", irq_valid); end
      total++; if (irq_id !== 8'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", irq_id); end
      total++; if (irq_level !== 8'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", irq_level); end
      total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", scan_busy); end
      rst = 1'b0;
      tick();
      total++; if (scan_busy !== 1'b1) begin bad++; $display("FAIL scan_starts: got %b want 1", scan_busy); end
   endtask

   task automatic test_basic();
      int n;
      clear_src();
      set_src(37, 5);
      do_reset();
      wait_valid(40, n);
      total++; if (n != 17) begin bad++; $display("FAIL basic_latency: got %0d want 17", n); end
      total++; if (irq_id !== 8'd37) begin bad++; $display("FAIL basic_id: got %0d want 37", irq_id); end
      total++; if (irq_level !== 8'd5) begin bad++; $display("FAIL basic_level: got %0d want 5", irq_level); end
      total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL hold_busy: got %b want 0", scan_busy); end
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL claim_drop: got %b want 0", irq_valid); end
      wait_valid(40, n);
      total++; if (n != 17) begin bad++; $display("FAIL reoffer_latency: got %0d want 17", n); end
      total++; if (irq_id !== 8'd37) begin bad++; $display("FAIL reoffer_id: got %0d want 37", irq_id); end
   endtask

   task automatic test_priority();
      int n;
      clear_src();
      set_src(3, 9);
      set_src(200, 9);
      set_src(100, 8);
      do_reset();
      wait_valid(40, n);
      total++; if (irq_id !== 8'd3) begin bad++; $display("FAIL cross_tie_id: got %0d want 3", irq_id); end
      total++; if (irq_level !== 8'd9) begin bad++; $display("FAIL cross_tie_level: got %0d want 9", irq_level); end
      clear_src();
      set_src(18, 5);
      set_src(21, 6);
      set_src(20, 6);
      do_reset();
      wait_valid(40, n);
      total++; if (irq_id !== 8'd20) begin bad++; $display("FAIL chunk_tie_id: got %0d want 20", irq_id); end
      clear_src();
      set_src(5, 3);
      set_src(240, 10);
      do_reset();
      wait_valid(40, n);
      total++; if (irq_id !== 8'd240) begin bad++; $display("FAIL later_higher_id: got %0d want 240", irq_id); end
      total++; if (irq_level !== 8'd10) begin bad++; $display("FAIL later_higher_level: got %0d want 10", irq_level); end
   endtask

   task automatic test_threshold();
      int n;
      clear_src();
      set_src(12, 4);
      // Pending but masked source must be ignored despite its high level.
      ip[13]            = 1'b1;
      level[13*8 +: 8]  = 8'd200;
      mth = 8'd4;
      do_reset();
      wait_valid(60, n);
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL level_eq_mth: got %b want 0", irq_valid); end
      mth = 8'd3;
      wait_valid(40, n);
      total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL mth_lowered_valid: got %b want 1", irq_valid); end
      total++; if (irq_id !== 8'd12) begin bad++; $display("FAIL mth_lowered_id: got %0d want 12", irq_id); end
   endtask

   task automatic test_withdraw();
      int n;
      clear_src();
      set_src(50, 6);
      do_reset();
      wait_valid(40, n);
      total++; if (irq_id !== 8'd50) begin bad++; $display("FAIL wd_id: got %0d want 50", irq_id); end
      ie[50] = 1'b0;
      tick();
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL wd_ie_drop: got %b want 0", irq_valid); end
      ie[50] = 1'b1;
      wait_valid(40, n);
      total++; if (n != 17) begin bad++; $display("FAIL wd_reoffer: got %0d want 17", n); end
      mth = 8'd6;
      tick();
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL wd_level_drop: got %b want 0", irq_valid); end
      mth = 8'd0;
      wait_valid(40, n);
      ie[50]    = 1'b0;
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL wd_claim_drop: got %b want 0", irq_valid); end
      tick();
      total++; if (scan_busy !== 1'b1) begin bad++; $display("FAIL wd_claim_rescan: got %b want 1", scan_busy); end
   endtask

   task automatic test_midscan_reset();
      int n;
      clear_src();
      set_src(37, 5);
      do_reset();
      repeat (8) tick();
      total++; if (scan_busy !== 1'b1) begin bad++; $display("FAIL midscan_busy: got %b want 1", scan_busy); end
      rst = 1'b1;
      tick();
      total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL midscan_rst_busy: got %b want 0", scan_busy); end
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL midscan_rst_valid: got %b want 0", irq_valid); end
      rst = 1'b0;
      wait_valid(40, n);
      total++; if (n != 17) begin bad++; $display("FAIL midscan_latency: got %0d want 17", n); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL hold_rst_valid: got %b want 0", irq_valid); end
      total++; if (irq_level !== 8'd0) begin bad++; $display("FAIL hold_rst_level: got %0d want 0", irq_level); end
   endtask

   task automatic test_preempt();
      int n;
      logic stayed;
      logic [7:0] want_id;
      logic [7:0] want_lvl;
`ifdef CLIC_ARB_PREEMPT_EN
      want_id  = 8'd250;
      want_lvl = 8'd7;
`else
      want_id  = 8'd10;
      want_lvl = 8'd2;
`endif
      clear_src();
      set_src(10, 2);
      do_reset();
      wait_valid(40, n);
      total++; if (irq_id !== 8'd10) begin bad++; $display("FAIL pre_hold_id: got %0d want 10", irq_id); end
      set_src(250, 7);
      stayed = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!irq_valid) stayed = 1'b0;
      end
      total++; if (stayed !== 1'b1) begin bad++; $display("FAIL pre_valid_held: got %b want 1", stayed); end
      total++; if (irq_id !== want_id) begin bad++; $display("FAIL pre_id: got %0d want %0d", irq_id, want_id); end
      total++; if (irq_level !== want_lvl) begin bad++; $display("FAIL pre_level: got %0d want %0d", irq_level, want_lvl); end
   endtask

   initial begin
      rst = 1'b1;
      clear_src();
      test_reset();
      test_basic();
      test_priority();
      test_threshold();
      test_withdraw();
      test_midscan_reset();
      test_preempt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
